fft_input_loader: RTL and testbench

- Synthesizable front end of fft_top. Captures a stream of signed ADC samples and distributes them over N_BANK write ports of the FFT input RAM, DEPTH words per bank.
- Fires a one-cycle start pulse once a full frame is written, then waits for the FFT ready rising edge.
- Replaces hand-driven bank/address/WE sequencing, and adds interleaved bank mapping, continuous re-arm, overrun flagging and a frame counter.

---
 rtl/fft_input_loader.sv | 169 ++++++++++++++++
 tb/tb_fft_input_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : fft_input_loader
// Brief    : Streams signed ADC samples into N_BANK FFT input RAM banks and
//            launches the FFT once a full frame has been written.
// Revision : 1.0 - initial release
// ============================================================================
module fft_input_loader #(
   parameter int DATA_W = 16,
   parameter int N_BANK = 4,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int BANK_W = $clog2(N_BANK)
) (
   input  logic                     iCLK,
   input  logic                     iRESET,
   input  logic                     iARM,
   input  logic                     iMODE,
   input  logic                     iCONT,
   input  logic                     iVALID,
   input  logic [DATA_W-1:0]        iDATA,
   input  logic                     iFFT_RDY,
   output logic [DATA_W-1:0]        oDATA,
   output logic [N_BANK*ADDR_W-1:0] oADDR_WR,
   output logic [N_BANK-1:0]        oWE,
   output logic                     oFFT_START,
   output logic                     oBUSY,
   output logic                     oOVERRUN,
   output logic [15:0]              oFRAME_CNT
);

   localparam int                 c_CNT_W = ADDR_W + BANK_W;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N_BANK*DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_LAUNCH = 2'd2,
      S_WAIT   = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [c_CNT_W-1:0]   r_n;
   logic                 r_mode;
   logic                 r_cont;
   logic                 r_rdy_q;

   logic                 w_arm;
   logic                 w_accept;
   logic                 w_rdy_rise;
   logic                 w_done;
   logic [BANK_W-1:0]    w_bank;
   logic [ADDR_W-1:0]    w_addr;

   assign w_arm      = (r_state == S_IDLE) && iARM;
   assign w_accept   = (r_state == S_FILL) && iVALID;
   assign w_rdy_rise = iFFT_RDY && !r_rdy_q;
   assign w_done     = (r_state == S_WAIT) && w_rdy_rise;

   // Block mode fills bank 0 first; interleaved mode rotates banks every sample.
   always_comb begin
      w_bank = '0;
      w_addr = '0;
      if (r_mode) begin
         w_bank = r_n[BANK_W-1:0];
         w_addr = r_n[c_CNT_W-1:BANK_W];
      end else begin
         w_bank = r_n[c_CNT_W-1:ADDR_W];
         w_addr = r_n[ADDR_W-1:0];
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (iARM) begin
               w_next_state = S_FILL;
            end
         end
         S_FILL: begin
            if (iVALID && (r_n == c_LAST)) begin
               w_next_state = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (w_rdy_rise) begin
               w_next_state = r_cont ? S_FILL : S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         r_n        <= '0;
         r_mode     <= 1'b0;
         r_cont     <= 1'b0;
         r_rdy_q    <= 1'b0;
         oDATA      <= '0;
         oWE        <= '0;
         oFFT_START <= 1'b0;
         oBUSY      <= 1'b0;
         oOVERRUN   <= 1'b0;
         oFRAME_CNT <= '0;
      end else begin
         r_rdy_q    <= iFFT_RDY;
         oFFT_START <= (r_state == S_LAUNCH);
         oBUSY      <= (w_next_state != S_IDLE);
         oWE        <= '0;

         if (w_arm) begin
            r_mode <= iMODE;
            r_cont <= iCONT;
         end

         if (w_arm || w_done) begin
            r_n <= '0;
         end else if (w_accept) begin
            r_n <= r_n + 1'b1;
         end

         if (w_accept) begin
            oDATA <= iDATA;
            oWE   <= N_BANK'(1) << w_bank;
         end

         // An accepted arm starts a fresh frame, so it outranks a stray sample.
         if (w_arm) begin
            oOVERRUN <= 1'b0;
         end else if (iVALID && (r_state != S_FILL)) begin
            oOVERRUN <= 1'b1;
         end

         if (w_done) begin
            oFRAME_CNT <= oFRAME_CNT + 16'd1;
         end
      end
   end

   generate
      for (genvar k = 0; k < N_BANK; k++) begin : g_bank_addr
         always_ff @(posedge iCLK or posedge iRESET) begin
            if (iRESET) begin
               oADDR_WR[k*ADDR_W +: ADDR_W] <= '0;
            end else if (w_accept && (w_bank == BANK_W'(k))) begin
               oADDR_WR[k*ADDR_W +: ADDR_W] <= w_addr;
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fft_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_input_loader
// Brief    : Self-checking bench for fft_input_loader with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_input_loader;

   localparam int DATA_W = 16;
   localparam int N_BANK = 4;
   localparam int DEPTH  = 512;
   localparam int ADDR_W = 9;
   localparam int TOTAL  = N_BANK * DEPTH;

   localparam int M_IDLE   = 0;
   localparam int M_FILL   = 1;
   localparam int M_LAUNCH = 2;
   localparam int M_WAIT   = 3;

   logic                     clk = 1'b0;
   logic                     iRESET = 1'b1;
   logic                     iARM = 1'b0;
   logic                     iMODE = 1'b0;
   logic                     iCONT = 1'b0;
   logic                     iVALID = 1'b0;
   logic [DATA_W-1:0]        iDATA = '0;
   logic                     iFFT_RDY = 1'b0;
   logic [DATA_W-1:0]        oDATA;
   logic [N_BANK*ADDR_W-1:0] oADDR_WR;
   logic [N_BANK-1:0]        oWE;
   logic                     oFFT_START;
   logic                     oBUSY;
   logic                     oOVERRUN;
   logic [15:0]              oFRAME_CNT;

   fft_input_loader dut (
      .iCLK      (clk),
      .iRESET    (iRESET),
      .iARM      (iARM),
      .iMODE     (iMODE),
      .iCONT     (iCONT),
      .iVALID    (iVALID),
      .iDATA     (iDATA),
      .iFFT_RDY  (iFFT_RDY),
      .oDATA     (oDATA),
      .oADDR_WR  (oADDR_WR),
      .oWE       (oWE),
      .oFFT_START(oFFT_START),
      .oBUSY     (oBUSY),
      .oOVERRUN  (oOVERRUN),
      .oFRAME_CNT(oFRAME_CNT)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;
   int we_cnt = 0;
   int start_cnt = 0;

   // Frame-level model: state of the capture, plus outputs due next cycle
   // (pend_*) and outputs visible this cycle (vis_*).
   int                       m_st = M_IDLE;
   int                       m_n = 0;
   bit                       m_mode = 0, m_cont = 0, m_ovr = 0, m_prev = 0;
   int                       m_frames = 0;
   logic [N_BANK-1:0]        pend_we = '0, vis_we = '0;
   logic [N_BANK*ADDR_W-1:0] pend_addr = '0, vis_addr = '0;
   logic [DATA_W-1:0]        pend_data = '0, vis_data = '0;
   logic                     pend_start = 0, vis_start = 0;
   logic                     pend_busy = 0, vis_busy = 0;
   logic                     pend_ovr = 0, vis_ovr = 0;
   logic [15:0]              pend_frames = '0, vis_frames = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("we", 64'(oWE), 64'(vis_we));
         chk("addr", 64'(oADDR_WR), 64'(vis_addr));
         chk("data", 64'(oDATA), 64'(vis_data));
         chk("start", 64'(oFFT_START), 64'(vis_start));
         chk("busy", 64'(oBUSY), 64'(vis_busy));
         chk("overrun", 64'(oOVERRUN), 64'(vis_ovr));
         chk("frame_cnt", 64'(oFRAME_CNT), 64'(vis_frames));
         if (oWE != '0) we_cnt++;
         if (oFFT_START) start_cnt++;
      end
   end

   task automatic model_reset();
      m_st = M_IDLE; m_n = 0; m_ovr = 0; m_prev = 0; m_frames = 0;
      pend_we = '0; vis_we = '0; pend_addr = '0; vis_addr = '0;
      pend_data = '0; vis_data = '0; pend_start = 0; vis_start = 0;
      pend_busy = 0; vis_busy = 0; pend_ovr = 0; vis_ovr = 0;
      pend_frames = '0; vis_frames = '0;
   endtask

   // One clock of stimulus; the model advances from the state the DUT holds
   // during this cycle.
   task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit a, input bit r);
      int b, ad;
      @(posedge clk); #1;
      iVALID = v; iDATA = d; iARM = a; iFFT_RDY = r;
      vis_we = pend_we; vis_addr = pend_addr; vis_data = pend_data;
      vis_start = pend_start; vis_busy = pend_busy; vis_ovr = pend_ovr;
      vis_frames = pend_frames;
      pend_we = '0;
      pend_start = (m_st == M_LAUNCH);
      case (m_st)
         M_IDLE: begin
            if (v) m_ovr = 1;
            if (a) begin
               m_st = M_FILL; m_n = 0; m_ovr = 0; m_mode = iMODE; m_cont = iCONT;
            end
         end
         M_FILL: begin
            if (v) begin
               if (m_mode) begin b = m_n % N_BANK; ad = m_n / N_BANK; end
               else        begin b = m_n / DEPTH;  ad = m_n % DEPTH;  end
               pend_we = N_BANK'(1 << b);
               pend_addr[b*ADDR_W +: ADDR_W] = ADDR_W'(ad);
               pend_data = d;
               m_n++;
               if (m_n == TOTAL) m_st = M_LAUNCH;
            end
         end
         M_LAUNCH: begin
            if (v) m_ovr = 1;
            m_st = M_WAIT;
         end
         default: begin
            if (v) m_ovr = 1;
            if (r && !m_prev) begin
               m_frames = (m_frames + 1) % 65536;
               m_st = m_cont ? M_FILL : M_IDLE;
               m_n = 0;
            end
         end
      endcase
      m_prev = r;
      pend_busy = (m_st != M_IDLE);
      pend_ovr = m_ovr;
      pend_frames = 16'(m_frames);
   endtask

   // Hand-computed expectations for the write of sample k, now visible.
   task automatic lit(input int k);
      if (!iMODE) begin
         if (k == 0) begin
            chk("lit_blk_s0_we", 64'(oWE), 64'b0001);
            chk("lit_blk_s0_addr", 64'(oADDR_WR[8:0]), 64'd0);
         end
         if (k == 513) begin
            chk("lit_blk_s513_we", 64'(oWE), 64'b0010);
            chk("lit_blk_s513_addr", 64'(oADDR_WR[17:9]), 64'd1);
            chk("lit_blk_s513_data", 64'(oDATA), 64'd513);
         end
      end else if (k == 5) begin
         chk("lit_il_s5_we", 64'(oWE), 64'b0010);
         chk("lit_il_s5_addr", 64'(oADDR_WR[17:9]), 64'd1);
         chk("lit_il_s5_data", 64'(oDATA), 64'd5);
      end
      if (k == 2047) begin
         chk("lit_s2047_we", 64'(oWE), 64'b1000);
         chk("lit_s2047_addr", 64'(oADDR_WR[35:27]), 64'd511);
      end
   endtask

   task automatic feed(input bit do_arm, input bit gaps, input bit rdy);
      int last;
      last = -1;
      if (do_arm) step(0, '0, 1, rdy);
      for (int n = 0; n < TOTAL; n++) begin
         step(1, DATA_W'(n), 0, rdy);
         lit(last);
         if (do_arm && n == 0) begin
            chk("busy_after_arm", 64'(oBUSY), 64'd1);
            chk("overrun_cleared_by_arm", 64'(oOVERRUN), 64'd0);
         end
         last = n;
         if (gaps && n < TOTAL - 1) begin
            int g;
            g = int'($urandom_range(0, 3));
            repeat (g) begin
               step(0, '0, 0, rdy);
               lit(last);
               last = -1;
            end
         end
      end
      step(0, '0, 0, rdy);
      lit(last);
      step(0, '0, 0, rdy);
      chk("start_after_last_we", 64'(oFFT_START), 64'd1);
   endtask

   task automatic complete();
      step(0, '0, 0, 1);
      step(0, '0, 0, 0);
   endtask

   task automatic async_reset();
      @(negedge clk); #1;
      iVALID = 0; iARM = 0; iFFT_RDY = 0; iRESET = 1;
      model_reset();
      #1;
      chk("rst_we", 64'(oWE), 64'd0);
      chk("rst_addr", 64'(oADDR_WR), 64'd0);
      chk("rst_data", 64'(oDATA), 64'd0);
      chk("rst_start", 64'(oFFT_START), 64'd0);
      chk("rst_busy", 64'(oBUSY), 64'd0);
      chk("rst_overrun", 64'(oOVERRUN), 64'd0);
      chk("rst_frame_cnt", 64'(oFRAME_CNT), 64'd0);
      repeat (2) @(posedge clk);
      #1 iRESET = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("init_we", 64'(oWE), 64'd0);
      chk("init_busy", 64'(oBUSY), 64'd0);
      chk("init_frame_cnt", 64'(oFRAME_CNT), 64'd0);
      iRESET = 0;
      repeat (3) step(0, '0, 0, 0);

      // Block mode, gap-free, then a stray sample in IDLE.
      iMODE = 0; iCONT = 0; start_cnt = 0;
      feed(1, 0, 0);
      repeat (5) step(0, '0, 0, 0);
      chk("blk_one_start", 64'(start_cnt), 64'd1);
      complete();
      chk("blk_frame_cnt", 64'(oFRAME_CNT), 64'd1);
      chk("blk_busy_fall", 64'(oBUSY), 64'd0);
      step(1, 16'h1234, 0, 0);
      step(0, '0, 0, 0);
      chk("idle_overrun", 64'(oOVERRUN), 64'd1);
      chk("idle_no_we", 64'(oWE), 64'd0);

      // Interleaved mode with FFT ready held high across the launch.
      iMODE = 1;
      feed(1, 0, 1);
      repeat (10) step(0, '0, 0, 1);
      chk("held_rdy_no_done", 64'(oFRAME_CNT), 64'd1);
      chk("held_rdy_busy", 64'(oBUSY), 64'd1);
      repeat (100) step(0, '0, 0, 0);
      step(0, '0, 0, 1);
      step(0, '0, 0, 1);
      chk("rise_done_cnt", 64'(oFRAME_CNT), 64'd2);
      chk("rise_done_idle", 64'(oBUSY), 64'd0);

      // Block mode with random gaps between samples.
      iMODE = 0; we_cnt = 0;
      feed(1, 1, 0);
      chk("gap_we_count", 64'(we_cnt), 64'd2048);
      complete();
      chk("gap_frame_cnt", 64'(oFRAME_CNT), 64'd3);

      // Continuous mode, three completions, overrun while waiting.
      async_reset();
      iMODE = 1; iCONT = 1; start_cnt = 0;
      feed(1, 0, 0);
      step(1, 16'hBEEF, 0, 0);
      step(0, '0, 0, 0);
      chk("wait_overrun", 64'(oOVERRUN), 64'd1);
      complete();
      feed(0, 0, 0);
      repeat (3) step(0, '0, 0, 0);
      complete();
      feed(0, 0, 0);
      complete();
      chk("cont_frame_cnt", 64'(oFRAME_CNT), 64'd3);
      chk("cont_starts", 64'(start_cnt), 64'd3);
      chk("cont_overrun_held", 64'(oOVERRUN), 64'd1);
      chk("cont_rearmed_busy", 64'(oBUSY), 64'd1);

      // Asynchronous reset at sample 700, then a fresh block-mode frame.
      start_cnt = 0;
      for (int n = 0; n <= 700; n++) step(1, DATA_W'(n), 0, 0);
      async_reset();
      iMODE = 0; iCONT = 0;
      repeat (5) step(0, '0, 0, 0);
      chk("reset_no_start", 64'(start_cnt), 64'd0);
      feed(1, 0, 0);
      complete();
      chk("refill_start_cnt", 64'(start_cnt), 64'd1);
      chk("refill_frame_cnt", 64'(oFRAME_CNT), 64'd1);
      repeat (3) step(0, '0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
